// File: rtl/loop_cnn_seq.sv
// Sequential KxK signed convolution over an IMG_W x IMG_W map with one MAC;
// each output pixel takes K*K MAC cycles plus one write cycle; start is ignored while busy.
module loop_cnn_seq #(
    parameter int IMG_W  = 6,
    parameter int DW     = 8,
    parameter int K      = 3,
    parameter int WW     = 8,
    parameter int STRIDE = 1,
    parameter int ACC_W  = 20,
    parameter int OUT_W  = 16,
    parameter int OUT_DIM = (IMG_W - K) / STRIDE + 1,
    parameter int OUT_N   = OUT_DIM * OUT_DIM
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       relu_en,
    input  logic [IMG_W*IMG_W*DW-1:0]  input_fm,
    input  logic [K*K*WW-1:0]          weights,
    output logic                       busy,
    output logic                       done,
    output logic [OUT_N*OUT_W-1:0]     output_fm
);

    localparam int RCW = $clog2(OUT_DIM + 1);
    localparam int KW  = $clog2(K + 1);
    localparam logic [RCW-1:0] LAST_RC = RCW'(OUT_DIM - 1);
    localparam logic [KW-1:0]  LAST_K  = KW'(K - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, MAC, WRITE, DONE} state_t;

    state_t                      state;
    logic [IMG_W*IMG_W*DW-1:0]   fm_q;
    logic [K*K*WW-1:0]           w_q;
    logic                        relu_q;
    logic [RCW-1:0]              r;
    logic [RCW-1:0]              c;
    logic [KW-1:0]               ki;
    logic [KW-1:0]               kj;
    logic signed [ACC_W-1:0]     acc;

    int                          pix_idx;
    int                          w_idx;
    int                          out_idx;
    logic signed [DW-1:0]        pix;
    logic signed [WW-1:0]        wt;
    logic signed [DW+WW-1:0]     prod;
    logic signed [ACC_W-1:0]     prod_ext;
    logic [OUT_W-1:0]            res;

    always_comb begin
        pix_idx  = (int'(r) * STRIDE + int'(ki)) * IMG_W + int'(c) * STRIDE + int'(kj);
        w_idx    = int'(ki) * K + int'(kj);
        out_idx  = int'(r) * OUT_DIM + int'(c);
        pix      = fm_q[pix_idx*DW +: DW];
        wt       = w_q[w_idx*WW +: WW];
        prod     = pix * wt;
        prod_ext = {{(ACC_W-DW-WW){prod[DW+WW-1]}}, prod};
        // ReLU takes precedence, so a negative accumulator never saturates to the minimum
        if (relu_q && acc[ACC_W-1])
            res = '0;
        else if (acc > SAT_MAX)
            res = SAT_MAX[OUT_W-1:0];
        else if (acc < SAT_MIN)
            res = SAT_MIN[OUT_W-1:0];
        else
            res = acc[OUT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            output_fm <= '0;
            fm_q      <= '0;
            w_q       <= '0;
            relu_q    <= 1'b0;
            r         <= '0;
            c         <= '0;
            ki        <= '0;
            kj        <= '0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    fm_q      <= input_fm;
                    w_q       <= weights;
                    relu_q    <= relu_en;
                    output_fm <= '0;
                    r         <= '0;
                    c         <= '0;
                    ki        <= '0;
                    kj        <= '0;
                    acc       <= '0;
                    state     <= MAC;
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    if (kj == LAST_K) begin
                        kj <= '0;
                        if (ki == LAST_K) begin
                            ki    <= '0;
                            state <= WRITE;
                        end else begin
                            ki <= ki + 1'b1;
                        end
                    end else begin
                        kj <= kj + 1'b1;
                    end
                end
                WRITE: begin
                    output_fm[out_idx*OUT_W +: OUT_W] <= res;
                    acc   <= '0;
                    state <= MAC;
                    if (c == LAST_RC) begin
                        c <= '0;
                        if (r == LAST_RC) begin
                            r     <= '0;
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            r <= r + 1'b1;
                        end
                    end else begin
                        c <= c + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loop_cnn_seq.sv
// Directed bench for loop_cnn_seq: default 6x6/3x3 instance plus a K=2, STRIDE=2 variant.
module tb_loop_cnn_seq;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           start2 = 1'b0;
    logic           relu_en = 1'b0;
    logic [287:0]   input_fm = '0;
    logic [71:0]    weights = '0;
    logic [31:0]    weights2 = '0;
    logic           busy, done, busy2, done2;
    logic [255:0]   output_fm;
    logic [143:0]   output_fm2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    loop_cnn_seq u_dut (
        .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
        .input_fm(input_fm), .weights(weights),
        .busy(busy), .done(done), .output_fm(output_fm)
    );

    loop_cnn_seq #(.IMG_W(6), .K(2), .STRIDE(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .relu_en(relu_en),
        .input_fm(input_fm), .weights(weights2),
        .busy(busy2), .done(done2), .output_fm(output_fm2)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int px1(input int r, input int c);
        logic signed [15:0] v;
        v = output_fm[(r*4+c)*16 +: 16];
        return int'(v);
    endfunction

    function automatic int px2(input int r, input int c);
        logic signed [15:0] v;
        v = output_fm2[(r*3+c)*16 +: 16];
        return int'(v);
    endfunction

    task automatic fill_fm(input int v);
        for (int i = 0; i < 36; i++) input_fm[i*8 +: 8] = 8'(v);
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) input_fm[(r*6+c)*8 +: 8] = 8'(r*6 + c - 18);
    endtask

    task automatic fill_w(input int v);
        for (int i = 0; i < 9; i++) weights[i*8 +: 8] = 8'(v);
    endtask

    // Runs one job on the selected instance; poke injects start/input changes mid-job and in DONE.
    task automatic run_job(input string tag, input bit sel, input int exp_lat, input bit poke);
        int n;
        int busy_low;
        bit seen;
        n = 0; busy_low = 0; seen = 0;
        if (sel) start2 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start2 = 1'b0;
        while (n < 2000 && !seen) begin
            @(posedge clk); #1;
            n++;
            if (poke && n == 50) begin
                start = 1'b1;
                input_fm = {9{$urandom()}};
            end
            if (poke && n == 51) start = 1'b0;
            if (sel ? done2 : done) seen = 1'b1;
            else if (!(sel ? busy2 : busy)) busy_low++;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_busy_during_job"}, busy_low, 0);
        chk({tag, "_busy_at_done"}, int'(sel ? busy2 : busy), 0);
        if (poke) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_done_one_cycle"}, int'(sel ? done2 : done), 0);
        if (poke) begin
            n = 0;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                n += int'(busy) + int'(done);
            end
            chk({tag, "_start_in_done_ignored"}, n, 0);
        end
    endtask

    task automatic chk_all1(input string tag, input int exp);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                chk($sformatf("%s_px%0d%0d", tag, r, c), px1(r, c), exp);
    endtask

    task automatic chk_ident(input string tag, input bit relu);
        int e;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                e = (r + 1) * 6 + (c + 1) - 18;
                if (relu && e < 0) e = 0;
                chk($sformatf("%s_px%0d%0d", tag, r, c), px1(r, c), e);
            end
    endtask

    initial begin
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_out_zero", int'(|output_fm), 0);
        chk("rst_out2_zero", int'(|output_fm2), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // all ones
        fill_fm(1); fill_w(1); relu_en = 1'b0;
        run_job("ones", 1'b0, 161, 1'b0);
        chk_all1("ones", 9);

        // identity kernel, with and without ReLU
        fill_ramp(); fill_w(0); weights[4*8 +: 8] = 8'sd1;
        run_job("ident", 1'b0, 161, 1'b0);
        chk_ident("ident", 1'b0);
        relu_en = 1'b1;
        run_job("ident_relu", 1'b0, 161, 1'b0);
        chk_ident("ident_relu", 1'b1);

        // saturation both ways, then ReLU on the negative case
        relu_en = 1'b0;
        fill_fm(127); fill_w(127);
        run_job("sat_pos", 1'b0, 161, 1'b0);
        chk_all1("sat_pos", 32767);
        fill_w(-128);
        run_job("sat_neg", 1'b0, 161, 1'b0);
        chk_all1("sat_neg", -32768);
        relu_en = 1'b1;
        run_job("sat_relu", 1'b0, 161, 1'b0);
        chk_all1("sat_relu", 0);

        // start while busy / in DONE, input change mid-job
        relu_en = 1'b0;
        fill_fm(1); fill_w(1);
        run_job("hs", 1'b0, 161, 1'b1);
        chk_all1("hs", 9);

        // reset mid-job
        fill_fm(1); fill_w(1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        chk("midrst_partial_out", int'(output_fm[15:0]), 9);
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_out_zero", int'(|output_fm), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        fill_w(2);
        run_job("after_rst", 1'b0, 161, 1'b0);
        chk_all1("after_rst", 18);

        // K=2, STRIDE=2 variant
        fill_fm(1);
        for (int i = 0; i < 4; i++) weights2[i*8 +: 8] = 8'sd1;
        run_job("var", 1'b1, 46, 1'b0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                chk($sformatf("var_px%0d%0d", r, c), px2(r, c), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/loop_cnn_seq.md
Name: loop_cnn_seq

Overview:
Parametrised, sequential successor to the combinational Loop_cnn convolution loop. It runs one K x K signed-weight convolution over a square IMG_W x IMG_W feature map using a single MAC, one output pixel per K*K+1 cycles. Stride, saturation width and optional ReLU are configurable. It sits between the feature-map buffer and the next CNN layer, with a start/busy/done handshake.

Parameters:
IMG_W, 6, input feature-map side length (pixels)
DW, 8, input pixel width, signed
K, 3, kernel side length
WW, 8, weight width, signed
STRIDE, 1, window step in both dimensions
ACC_W, 20, accumulator width; must be >= DW+WW+clog2(K*K)
OUT_W, 16, saturated output pixel width, signed
Derived: OUT_DIM = (IMG_W-K)/STRIDE+1 (default 4); OUT_N = OUT_DIM*OUT_DIM (default 16)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  job request; sampled only in IDLE
relu_en  in  1  ReLU enable; captured in LOAD
input_fm  in  IMG_W*IMG_W*DW  pixel (r,c) at bits [(r*IMG_W+c)*DW +: DW]
weights  in  K*K*WW  weight (i,j) at bits [(i*K+j)*WW +: WW]
busy  out  1  high in LOAD, MAC and WRITE
done  out  1  one-cycle pulse when the job completes
output_fm  out  OUT_N*OUT_W  output (r,c) at bits [(r*OUT_DIM+c)*OUT_W +: OUT_W]

Behaviour:
- Reset (async, any time, including mid-job): state=IDLE, busy=0, done=0, output_fm=0, all counters and the accumulator 0.
- FSM states: IDLE, LOAD, MAC, WRITE, DONE.
- IDLE: on start=1, go to LOAD. Otherwise stay.
- LOAD (1 cycle): register input_fm, weights and relu_en into internal copies. Clear output_fm to 0, clear row/col/ki/kj counters and the accumulator. Go to MAC. Input changes after LOAD do not affect the job.
- MAC (K*K cycles per pixel): each cycle, acc += sext(pix[r*STRIDE+ki][c*STRIDE+kj]) * sext(w[ki][kj]). The multiply is signed DW x WW, sign-extended to ACC_W. kj increments fastest; ki advances when kj wraps at K-1. After the (ki,kj)=(K-1,K-1) term, go to WRITE.
- WRITE (1 cycle): post-process acc to result:
  - If the captured relu_en=1 and acc<0, result=0.
  - Otherwise saturate acc to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Store result at output (r,c), then clear acc.
  - c increments. At OUT_DIM-1, c wraps to 0 and r increments.
  - After the last pixel (OUT_DIM-1, OUT_DIM-1), go to DONE. Otherwise go to MAC.
- DONE (1 cycle): done=1, busy=0, then go to IDLE. start is ignored in DONE.
- start while busy is ignored, with no queueing.
- Latency: with start sampled at edge E, done is high in the cycle following edge E+1+OUT_N*(K*K+1). With defaults that is E+161.
- Pixel (r,c) of output_fm becomes valid the cycle after its WRITE. Unwritten pixels read 0 during a job. output_fm holds its value after done until the next LOAD.

Test Plan:
1. Defaults, all pixels=1, all weights=1, relu_en=0, start pulse → every output = 9. done pulses exactly 161 edges after the start edge, busy high throughout the preceding 160 cycles.
2. Identity kernel (w[1][1]=1, others 0), input pixel (r,c) = r*6+c-18 → output (r,c) equals input (r+1,c+1), negative values preserved; repeat with relu_en=1 → negatives become 0.
3. Saturation: pixels=127, weights=127 → acc=145161 → all outputs 32767. Weights=-128 → acc=-146304 → all outputs -32768. Same with relu_en=1 → all outputs 0.
4. Handshake: assert start again at cycle 50 of a job and in the DONE cycle → ignored, exactly one done pulse. Change input_fm mid-job → results unchanged.
5. Reset mid-job (assert rst at cycle 80) → busy, done and output_fm are 0 immediately. A new start after release gives correct results with full latency.
6. Parameter variant IMG_W=6, K=2, STRIDE=2 → OUT_DIM=3, output_fm 144 bits. With all-ones input and weights, all outputs = 4, done after 1+9*5=46 edges.
